// File: rtl/vga_capture.sv
// VGA frame grabber: measures incoming sync timing, locks after one verified
// frame and streams active RGB565 pixels to a frame buffer write port.
module vga_capture #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [15:0] vga_rgb,
  input  logic        cap_en,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        line_err
);

  typedef enum logic [1:0] {S_UNLOCK, S_CHECK, S_CAPTURE, S_SKIP} state_t;

  localparam logic [9:0]  CNT_MAX   = '1;
  localparam logic [18:0] LAST_ADDR = 19'(H_DISP * V_DISP - 1);

  state_t      state, state_nxt;
  logic        hs_r, vs_r, hs_d, vs_d;
  logic [15:0] rgb_r;
  logic [9:0]  h_cnt, v_cnt;
  logic        hs_fall, vs_fall;
  logic        h_bad, v_bad, err;
  logic        frame_ok, frame_ok_nxt;
  logic        locked_nxt, start_nxt;
  logic        h_act, v_act, wr_nxt;
  logic [18:0] pix_idx;
  logic        frame_full;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      rgb_r <= '0;
    end else begin
      hs_r  <= vga_hs;
      vs_r  <= vga_vs;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      rgb_r <= vga_rgb;
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;

      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall && (v_cnt != CNT_MAX))
        v_cnt <= v_cnt + 10'd1;
    end
  end

  // A frame boundary line is judged by the frame check, not the line check.
  assign h_bad = hs_fall & ~vs_fall & ((32'(h_cnt) + 32'd1) != H_TOTAL);
  assign v_bad = vs_fall & ((32'(v_cnt) + 32'd1) != V_TOTAL);
  assign err   = h_bad | v_bad;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_UNLOCK;
      frame_ok <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame_ok <= frame_ok_nxt;
      locked   <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    frame_ok_nxt = frame_ok;
    locked_nxt   = locked;
    start_nxt    = 1'b0;
    case (state)
      S_UNLOCK: begin
        locked_nxt = 1'b0;
        if (vs_fall) begin
          state_nxt    = S_CHECK;
          frame_ok_nxt = 1'b1;
        end
      end
      S_CHECK: begin
        if (vs_fall) begin
          if (frame_ok && !err) begin
            locked_nxt = 1'b1;
            state_nxt  = cap_en ? S_CAPTURE : S_SKIP;
            start_nxt  = cap_en;
          end else begin
            frame_ok_nxt = 1'b1;
          end
        end else if (err) begin
          frame_ok_nxt = 1'b0;
        end
      end
      S_CAPTURE, S_SKIP: begin
        if (err) begin
          state_nxt  = S_UNLOCK;
          locked_nxt = 1'b0;
        end else if (vs_fall) begin
          state_nxt = cap_en ? S_CAPTURE : S_SKIP;
          start_nxt = cap_en;
        end
      end
      default: begin
        state_nxt  = S_UNLOCK;
        locked_nxt = 1'b0;
      end
    endcase
  end

  assign h_act = (32'(h_cnt) >= H_SYNC + H_BACK) &&
                 (32'(h_cnt) <  H_SYNC + H_BACK + H_DISP);
  assign v_act = (32'(v_cnt) >= V_SYNC + V_BACK) &&
                 (32'(v_cnt) <  V_SYNC + V_BACK + V_DISP);

  // Frame-boundary cycles carry stale counters, so they never write.
  assign wr_nxt = (state == S_CAPTURE) && !err && !vs_fall &&
                  h_act && v_act && !frame_full;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      pix_idx     <= '0;
      frame_full  <= 1'b0;
    end else begin
      wr_en       <= wr_nxt;
      frame_start <= start_nxt;
      frame_done  <= wr_nxt && (pix_idx == LAST_ADDR);
      line_err    <= err;
      if (start_nxt) begin
        pix_idx    <= '0;
        wr_addr    <= '0;
        frame_full <= 1'b0;
      end else if (wr_nxt) begin
        wr_addr <= pix_idx;
        wr_data <= rgb_r;
        pix_idx <= pix_idx + 19'd1;
        if (pix_idx == LAST_ADDR)
          frame_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Frame-level reference model of sync locking and pixel capture, driven with
// scaled-down video timing and randomized blanking data / reset placement.
module tb_vga_capture;

  localparam int HS = 3, HB = 2, HD = 8, HT = 16;
  localparam int VS = 2, VB = 2, VD = 5, VT = 11;
  localparam int LAST = HD * VD - 1;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic        vga_hs, vga_vs, cap_en;
  logic [15:0] vga_rgb;
  logic        wr_en, frame_start, frame_done, locked, line_err;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [39:0] act;

  vga_capture #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_rgb(vga_rgb), .cap_en(cap_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .frame_done(frame_done),
    .locked(locked), .line_err(line_err)
  );

  always #20 vga_clk = ~vga_clk;

  assign act = {wr_en, wr_addr, wr_data, frame_start, frame_done, locked, line_err};

  int unsigned n_tests, n_fail;
  int unsigned frame_no;
  // model: armed = a frame boundary has been seen since losing lock,
  // clean = no timing error since that boundary
  bit          armed, clean, lk, capturing, full, seen_hs, seen_vs;
  int unsigned cap_cnt, exp_wr, got_wr;
  int          line_len, frame_lines;
  logic [39:0] exp_prev, msk_prev;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp,
                       input logic [39:0] msk);
    n_tests++;
    assert ((got & msk) === (exp & msk)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got & msk, exp & msk);
    end
  endtask

  task automatic model_reset();
    armed = 0; clean = 0; lk = 0; capturing = 0; full = 0;
    seen_hs = 0; seen_vs = 0; cap_cnt = 0;
  endtask

  task automatic pin_step(input int y, input int h, input bit rst);
    logic [15:0] rgb;
    logic [39:0] e, m;
    int          hc;
    int unsigned addr_e;
    bit          pix, we, fs, fd, er, erx;
    // stage-1 column counter trails the sampled pixel by one clock
    hc  = h - 1;
    pix = (y >= VS + VB) && (y < VS + VB + VD) && (hc >= HS + HB) && (hc < HS + HB + HD);
    if (pix) rgb = {5'(hc - HS - HB), 6'(y - VS - VB), 5'(hc - HS - HB)};
    else     rgb = 16'($urandom);
    vga_hs = (h >= HS);
    vga_vs = (y >= VS);
    vga_rgb = rgb;
    we = 0; fs = 0; fd = 0; er = 0; erx = 0; addr_e = 0;
    if (rst) begin
      sys_rst = 1'b1;
      model_reset();
      #1;
      check("async_reset", act, '0, '1);
      e = '0; m = '1;
      exp_prev = '0; msk_prev = '1;
      exp_wr = 0; got_wr = 0;
    end else begin
      sys_rst = 1'b0;
      if (h == 0) begin
        if (y == 0) begin
          if (!seen_vs) erx = 1; else er = (frame_lines != VT);
          seen_vs = 1; seen_hs = 1;
          if (lk) begin
            if (er) begin lk = 0; armed = 0; end
          end else if (armed && clean && !er) begin
            lk = 1;
          end else begin
            armed = 1; clean = 1;
          end
          capturing = lk && cap_en;
          fs = capturing; cap_cnt = 0; full = 0;
        end else begin
          if (!seen_hs) erx = 1; else er = (line_len != HT);
          seen_hs = 1;
          if (er) begin
            capturing = 0;
            if (lk) begin lk = 0; armed = 0; end
            else clean = 0;
          end
        end
      end
      if (capturing && pix && !full) begin
        we = 1; addr_e = cap_cnt; fd = (cap_cnt == LAST);
        if (fd) full = 1;
        cap_cnt++; exp_wr++;
      end
      e = {we, 19'(addr_e), rgb, fs, fd, lk, er};
      m = {we, {19{we}}, {16{we}}, 3'b111, ~erx};
    end
    @(posedge vga_clk);
    #1;
    check($sformatf("out_f%0d_y%0d_h%0d", frame_no, y, h), act, exp_prev, msk_prev);
    if (wr_en) got_wr++;
    exp_prev = e; msk_prev = m;
  endtask

  task automatic run_frame(input int lines, input int short_line, input bit cap,
                           input int rst_line);
    int len, rst_h;
    rst_h = HS + int'($urandom_range(HT - HS - 5, 0));
    cap_en = cap;
    for (int y = 0; y < lines; y++) begin
      len = (y == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++)
        pin_step(y, h, (y == rst_line) && (h >= rst_h) && (h < rst_h + 3));
      line_len = len;
    end
    frame_lines = lines;
    check($sformatf("writes_f%0d", frame_no), 40'(got_wr), 40'(exp_wr), '1);
    exp_wr = 0; got_wr = 0;
    frame_no++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; frame_no = 0;
    sys_rst = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_rgb = '0; cap_en = 1'b0;
    model_reset();
    exp_prev = '0; msk_prev = '1; exp_wr = 0; got_wr = 0;
    line_len = HT; frame_lines = VT;
    #5;
    check("reset_state", act, '0, '1);
    repeat (3) pin_step(VT - 1, HT - 1, 1'b1);
    repeat (3) pin_step(VT - 1, HT - 1, 1'b0);

    run_frame(VT, -1, 1'b1, -1);       // verification frame
    run_frame(VT, -1, 1'b1, -1);       // locked, first capture
    run_frame(VT, -1, 1'b1, -1);
    run_frame(VT,  6, 1'b1, -1);       // 15-clock line aborts capture
    run_frame(VT, -1, 1'b1, -1);       // re-verification
    run_frame(VT, -1, 1'b1, -1);       // capture resumes
    run_frame(VT, -1, 1'b0, -1);       // skipped, stays locked
    run_frame(VT, -1, 1'b1, -1);       // capture from address 0 again
    run_frame(VT, -1, 1'b1,  6);       // reset mid-frame
    run_frame(VT, -1, 1'b1, -1);       // no writes
    run_frame(VT, -1, 1'b1, -1);       // writes resume
    run_frame(VT - 1, -1, 1'b1, -1);   // short frame, error at next boundary
    run_frame(VT, -1, 1'b1, -1);
    run_frame(VT, -1, 1'b1, -1);
    run_frame(VT, -1, 1'b1, -1);
    repeat (3) run_frame(VT, -1, 1'($urandom), -1);
    repeat (3) pin_step(VT - 1, HT - 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
